axi4_lite_regfile: RTL and testbench

AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

---
 rtl/axi4_lite_pkg.sv | 28 ++
 rtl/axi4_lite_regfile_bank.sv | 40 ++++
 rtl/axi4_lite_regfile.sv | 189 ++++++++++++++++++
 tb/tb_axi4_lite_regfile.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types for the register file: response codes and the
// write/read handshake state encodings.
package axi4_lite_pkg;

    localparam int REG_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic resp_t resp_of(input logic ok);
        return ok ? OKAY : SLVERR;
    endfunction

endpackage

// File: rtl/axi4_lite_regfile_bank.sv
// Register storage for the AXI4-Lite register file: byte-strobe merge on
// commit and a one-cycle wr_pulse for every committed write.
module axi4_lite_regfile_bank
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int IDX_W      = 6,
    parameter int DATA_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [IDX_W-1:0]            idx,
    input  logic [DATA_BYTES*8-1:0]     wdata,
    input  logic [DATA_BYTES-1:0]       wstrb,
    output logic [NUM_REGS*REG_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]         wr_pulse
);

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q    <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we && (idx == IDX_W'(i))) begin
                    // An all-zero strobe still counts as a committed write.
                    wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < DATA_BYTES; b++) begin
                        if (wstrb[b]) begin
                            reg_q[REG_W*i + 8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file with independent write and read handshakes.
// Optional privilege check enabled by defining AXI4_LITE_REGFILE_PROT_EN.
//
// state  | meaning
// W_IDLE | collecting AW and W beats; commit once both are held
// W_RESP | bvalid/bresp held until bready
// R_IDLE | arready high, waiting for an AR beat
// R_DATA | rvalid/rdata/rresp held until rready
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 1,
    parameter int NUM_REGS   = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [ADDR_BYTES*8-1:0]     awaddr,
    input  logic [2:0]                  awprot,
    input  logic                        wvalid,
    output logic                        wready,
    input  logic [DATA_BYTES*8-1:0]     wdata,
    input  logic [DATA_BYTES-1:0]       wstrb,
    output logic                        bvalid,
    input  logic                        bready,
    output logic [1:0]                  bresp,
    input  logic                        arvalid,
    output logic                        arready,
    input  logic [ADDR_BYTES*8-1:0]     araddr,
    input  logic [2:0]                  arprot,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [DATA_BYTES*8-1:0]     rdata,
    output logic [1:0]                  rresp,
    output logic [NUM_REGS*32-1:0]      reg_q,
    output logic [NUM_REGS-1:0]         wr_pulse
);

    localparam int ADDR_W = ADDR_BYTES * 8;
    localparam int DATA_W = DATA_BYTES * 8;
    localparam int IDX_W  = ADDR_W - 2;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < (IDX_W + 1)'(NUM_REGS);
    endfunction

    w_state_t               w_state;
    r_state_t               r_state;
    logic                   aw_held;
    logic                   w_held;
    logic [IDX_W-1:0]       aw_idx;
    logic [DATA_W-1:0]      w_data;
    logic [DATA_BYTES-1:0]  w_strb;
    logic [IDX_W-1:0]       ar_idx;
    logic [DATA_W-1:0]      rd_word;
    logic                   commit;
    logic                   w_ok;
    logic                   r_ok;
    logic                   w_prot_ok;
    logic                   r_prot_ok;
    logic                   unused_bits;

    assign ar_idx = araddr[ADDR_W-1:2];

`ifdef AXI4_LITE_REGFILE_PROT_EN
    logic aw_priv;

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_priv <= 1'b0;
        end else if (awvalid && awready) begin
            aw_priv <= awprot[0];
        end
    end

    assign w_prot_ok   = aw_priv;
    assign r_prot_ok   = arprot[0];
    assign unused_bits = ^{awprot[2:1], arprot[2:1], awaddr[1:0], araddr[1:0]};
`else
    assign w_prot_ok   = 1'b1;
    assign r_prot_ok   = 1'b1;
    assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
`endif

    // Ready flags are gated by reset so they read low while areset is high.
    assign awready = !areset && (w_state == W_IDLE) && !aw_held;
    assign wready  = !areset && (w_state == W_IDLE) && !w_held;
    assign arready = !areset && (r_state == R_IDLE);

    assign commit = (w_state == W_IDLE) && aw_held && w_held;
    assign w_ok   = in_range(aw_idx) && w_prot_ok;
    assign r_ok   = in_range(ar_idx) && r_prot_ok;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_word = reg_q[32*i +: 32];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        aw_held <= 1'b1;
                        aw_idx  <= awaddr[ADDR_W-1:2];
                    end
                    if (wvalid && wready) begin
                        w_held <= 1'b1;
                        w_data <= wdata;
                        w_strb <= wstrb;
                    end
                    if (commit) begin
                        w_state <= W_RESP;
                        bvalid  <= 1'b1;
                        bresp   <= resp_of(w_ok);
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // The bank updates on the same edge, so rd_word is still the pre-write value.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_state <= R_DATA;
                        rvalid  <= 1'b1;
                        rdata   <= r_ok ? rd_word : '0;
                        rresp   <= resp_of(r_ok);
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        r_state <= R_IDLE;
                        rvalid  <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi4_lite_regfile_bank #(
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .DATA_BYTES (DATA_BYTES)
    ) u_bank (
        .clk      (aclk),
        .rst      (areset),
        .we       (commit && w_ok),
        .idx      (aw_idx),
        .wdata    (w_data),
        .wstrb    (w_strb),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed self-checking bench for axi4_lite_regfile (default parameters,
// AXI4_LITE_REGFILE_PROT_EN undefined).
module tb_axi4_lite_regfile;

    logic         aclk;
    logic         areset;
    logic         awvalid, awready;
    logic [7:0]   awaddr;
    logic [2:0]   awprot;
    logic         wvalid, wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic         arvalid, arready;
    logic [7:0]   araddr;
    logic [2:0]   arprot;
    logic         rvalid, rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic [1023:0] reg_q;
    logic [31:0]  wr_pulse;

    int tests = 0;
    int fails = 0;
    logic [31:0] model [32];

    axi4_lite_regfile #(.DATA_BYTES(4), .ADDR_BYTES(1), .NUM_REGS(32)) dut (
        .aclk(aclk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic int first_reg_diff();
        for (int i = 0; i < 32; i++) begin
            if (reg_q[32*i +: 32] !== model[i]) return i;
        end
        return -1;
    endfunction

    task automatic send_aw_w(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_done, w_done, aw_hit, w_hit;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            @(negedge aclk);
            n++;
            if (aw_hit) begin awvalid = 0; aw_done = 1; end
            if (w_hit)  begin wvalid = 0;  w_done = 1;  end
        end
        if (!(aw_done && w_done)) begin
            tests++; fails++;
            $display("FAIL aw_w_accept: beats not accepted within 20 cycles");
            awvalid = 0; wvalid = 0;
        end
    endtask

    task automatic wait_b(output logic [31:0] pulses);
        int n;
        n = 0;
        pulses = wr_pulse;
        while (!bvalid && n < 20) begin
            @(negedge aclk);
            n++;
            pulses |= wr_pulse;
        end
        if (!bvalid) begin
            tests++; fails++;
            $display("FAIL bvalid_wait: no write response within 20 cycles");
        end
    endtask

    task automatic ack_b();
        bready = 1;
        @(negedge aclk);
        bready = 0;
    endtask

    task automatic send_ar(input logic [7:0] addr);
        bit hit;
        int n;
        hit = 0; n = 0;
        araddr = addr; arvalid = 1;
        while (!hit && n < 20) begin
            hit = arvalid && arready;
            @(negedge aclk);
            n++;
        end
        arvalid = 0;
        if (!hit) begin
            tests++; fails++;
            $display("FAIL ar_accept: AR beat not accepted within 20 cycles");
        end
    endtask

    task automatic wait_r();
        int n;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (!rvalid) begin
            tests++; fails++;
            $display("FAIL rvalid_wait: no read data within 20 cycles");
        end
    endtask

    task automatic ack_r();
        rready = 1;
        @(negedge aclk);
        rready = 0;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [31:0] pulses);
        send_aw_w(addr, data, strb);
        wait_b(pulses);
        resp = bresp;
        ack_b();
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        send_ar(addr);
        wait_r();
        data = rdata;
        resp = rresp;
        ack_r();
    endtask

    task automatic test_reset();
        int d;
        areset = 1;
        repeat (3) @(negedge aclk);
        tests++; if ({awready, wready, arready} !== 3'b000) begin fails++;
            $display("FAIL reset_ready: got %b expected 000", {awready, wready, arready}); end
        tests++; if ({bvalid, rvalid} !== 2'b00) begin fails++;
            $display("FAIL reset_valid: got %b expected 00", {bvalid, rvalid}); end
        tests++; if ({bresp, rresp, rdata} !== 36'h0) begin fails++;
            $display("FAIL reset_payload: bresp %b rresp %b rdata %h expected 0", bresp, rresp, rdata); end
        tests++; if (wr_pulse !== 32'h0) begin fails++;
            $display("FAIL reset_pulse: got %h expected 0", wr_pulse); end
        d = first_reg_diff();
        tests++; if (d >= 0) begin fails++;
            $display("FAIL reset_regs: reg %0d got %h expected %h", d, reg_q[32*d +: 32], model[d]); end
        areset = 0;
        #1;
        tests++; if ({awready, wready, arready} !== 3'b111) begin fails++;
            $display("FAIL post_reset_ready: got %b expected 111", {awready, wready, arready}); end
        @(negedge aclk);
    endtask

    task automatic test_write_read();
        logic [1:0] resp; logic [31:0] pulses, data; int d;
        axi_write(8'h44, 32'hDEADBEEF, 4'hF, resp, pulses);
        model[17] = 32'hDEADBEEF;
        tests++; if (resp !== 2'b00) begin fails++;
            $display("FAIL wr44_bresp: got %b expected 00", resp); end
        tests++; if (pulses !== 32'h0002_0000) begin fails++;
            $display("FAIL wr44_pulse: got %h expected 00020000", pulses); end
        tests++; if (wr_pulse !== 32'h0) begin fails++;
            $display("FAIL wr44_pulse_width: got %h expected 0 after response", wr_pulse); end
        d = first_reg_diff();
        tests++; if (d >= 0) begin fails++;
            $display("FAIL wr44_regs: reg %0d got %h expected %h", d, reg_q[32*d +: 32], model[d]); end
        axi_read(8'h44, data, resp);
        tests++; if (data !== 32'hDEADBEEF) begin fails++;
            $display("FAIL rd44_data: got %h expected deadbeef", data); end
        tests++; if (resp !== 2'b00) begin fails++;
            $display("FAIL rd44_rresp: got %b expected 00", resp); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] pulses, data; int d;
        axi_write(8'hC4, 32'hDEADBEEF, 4'hF, resp, pulses);
        tests++; if (resp !== 2'b10) begin fails++;
            $display("FAIL wrC4_bresp: got %b expected 10", resp); end
        tests++; if (pulses !== 32'h0) begin fails++;
            $display("FAIL wrC4_pulse: got %h expected 0", pulses); end
        d = first_reg_diff();
        tests++; if (d >= 0) begin fails++;
            $display("FAIL wrC4_regs: reg %0d got %h expected %h", d, reg_q[32*d +: 32], model[d]); end
        axi_read(8'hC4, data, resp);
        tests++; if (data !== 32'h0) begin fails++;
            $display("FAIL rdC4_data: got %h expected 0", data); end
        tests++; if (resp !== 2'b10) begin fails++;
            $display("FAIL rdC4_rresp: got %b expected 10", resp); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [31:0] pulses, data;
        wvalid = 1; wdata = 32'h12345678; wstrb = 4'b0101;
        tests++; if (wready !== 1'b1) begin fails++;
            $display("FAIL early_w_ready: got %b expected 1", wready); end
        @(negedge aclk);
        wvalid = 0;
        tests++; if ({wready, awready} !== 2'b01) begin fails++;
            $display("FAIL w_held_ready: wready/awready got %b expected 01", {wready, awready}); end
        repeat (2) @(negedge aclk);
        awvalid = 1; awaddr = 8'h08;
        tests++; if (awready !== 1'b1) begin fails++;
            $display("FAIL late_aw_ready: got %b expected 1", awready); end
        @(negedge aclk);
        awvalid = 0;
        wait_b(pulses);
        resp = bresp;
        ack_b();
        model[2] = 32'h00340078;
        tests++; if (resp !== 2'b00 || pulses !== 32'h4) begin fails++;
            $display("FAIL w_first_resp: bresp %b pulses %h expected 00 / 00000004", resp, pulses); end
        axi_read(8'h08, data, resp);
        tests++; if (data !== 32'h00340078) begin fails++;
            $display("FAIL w_first_data: got %h expected 00340078", data); end
    endtask

    task automatic test_wstrb_zero();
        logic [1:0] resp; logic [31:0] pulses; int d;
        axi_write(8'h14, 32'hFFFFFFFF, 4'h0, resp, pulses);
        tests++; if (resp !== 2'b00) begin fails++;
            $display("FAIL strb0_bresp: got %b expected 00", resp); end
        tests++; if (pulses !== 32'h20) begin fails++;
            $display("FAIL strb0_pulse: got %h expected 00000020", pulses); end
        d = first_reg_diff();
        tests++; if (d >= 0) begin fails++;
            $display("FAIL strb0_regs: reg %0d got %h expected %h", d, reg_q[32*d +: 32], model[d]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pulses; bit stable;
        send_aw_w(8'h0C, 32'hCAFEF00D, 4'hF);
        wait_b(pulses);
        model[3] = 32'hCAFEF00D;
        awvalid = 1; awaddr = 8'h10; wvalid = 1; wdata = 32'h11111111; wstrb = 4'hF;
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) stable = 0;
            @(negedge aclk);
        end
        tests++; if (!stable) begin fails++;
            $display("FAIL b_stall: bvalid %b bresp %b awready %b wready %b expected 1 00 0 0", bvalid, bresp, awready, wready); end
        tests++; if (reg_q[4*32 +: 32] !== 32'h0) begin fails++;
            $display("FAIL b_stall_nowrite: reg4 got %h expected 0", reg_q[4*32 +: 32]); end
        awvalid = 0; wvalid = 0;
        ack_b();
        tests++; if (bvalid !== 1'b0) begin fails++;
            $display("FAIL b_release: bvalid got %b expected 0", bvalid); end

        send_ar(8'h0C);
        wait_r();
        arvalid = 1; araddr = 8'h44;
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D || rresp !== 2'b00 || arready !== 1'b0) stable = 0;
            @(negedge aclk);
        end
        tests++; if (!stable) begin fails++;
            $display("FAIL r_stall: rvalid %b rdata %h rresp %b arready %b expected 1 cafef00d 00 0", rvalid, rdata, rresp, arready); end
        arvalid = 0;
        ack_r();
        tests++; if (rvalid !== 1'b0) begin fails++;
            $display("FAIL r_release: rvalid got %b expected 0", rvalid); end
    endtask

    task automatic test_read_during_commit();
        logic [1:0] resp; logic [31:0] data;
        awvalid = 1; awaddr = 8'h00; wvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        @(negedge aclk);
        awvalid = 0; wvalid = 0;
        arvalid = 1; araddr = 8'h00;
        tests++; if ({arready, bvalid} !== 2'b10) begin fails++;
            $display("FAIL rdc_setup: arready/bvalid got %b expected 10", {arready, bvalid}); end
        @(negedge aclk);
        arvalid = 0;
        model[0] = 32'hA5A5A5A5;
        tests++; if ({rvalid, bvalid} !== 2'b11) begin fails++;
            $display("FAIL rdc_valid: rvalid/bvalid got %b expected 11", {rvalid, bvalid}); end
        tests++; if (rdata !== 32'h0 || rresp !== 2'b00) begin fails++;
            $display("FAIL rdc_old_value: rdata %h rresp %b expected 00000000 00", rdata, rresp); end
        bready = 1; rready = 1;
        @(negedge aclk);
        bready = 0; rready = 0;
        axi_read(8'h00, data, resp);
        tests++; if (data !== 32'hA5A5A5A5) begin fails++;
            $display("FAIL rdc_new_value: got %h expected a5a5a5a5", data); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] pulses; int d; bit any_b;
        send_aw_w(8'h18, 32'h00000066, 4'hF);
        wait_b(pulses);
        tests++; if (reg_q[6*32 +: 32] !== 32'h66) begin fails++;
            $display("FAIL rm_written: reg6 got %h expected 00000066", reg_q[6*32 +: 32]); end
        areset = 1;
        @(negedge aclk);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        tests++; if ({bvalid, awready} !== 2'b00) begin fails++;
            $display("FAIL rm_in_reset: bvalid/awready got %b expected 00", {bvalid, awready}); end
        d = first_reg_diff();
        tests++; if (d >= 0) begin fails++;
            $display("FAIL rm_regs: reg %0d got %h expected %h", d, reg_q[32*d +: 32], model[d]); end
        areset = 0;
        #1;
        tests++; if ({awready, wready, arready} !== 3'b111) begin fails++;
            $display("FAIL rm_ready: got %b expected 111", {awready, wready, arready}); end
        any_b = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            if (bvalid !== 1'b0) any_b = 1;
        end
        tests++; if (any_b) begin fails++;
            $display("FAIL rm_no_resp: bvalid seen after reset, expected none"); end
    endtask

    initial begin
        areset = 1;
        awvalid = 0; awaddr = 0; awprot = 3'b000;
        wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0;
        arvalid = 0; araddr = 0; arprot = 3'b000;
        rready = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge aclk);
        test_reset();
        test_write_read();
        test_out_of_range();
        test_w_before_aw();
        test_wstrb_zero();
        test_backpressure();
        test_read_during_commit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
